airi5c_dmem_ctrl: RTL and testbench

//  Data-memory access controller between the EX-stage load/store request (address from the dmem address latch)
//  and the AHB-Lite data bus. Checks alignment, runs a 2-phase single transfer (NONSEQ, no bursts),

---
 rtl/airi5c_dmem_ctrl.sv | 136 +++++++++++++
 tb/tb_airi5c_dmem_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/airi5c_dmem_ctrl.sv
// rtl/airi5c_dmem_ctrl.sv - data-memory access controller (EX load/store to AHB-Lite)
//
// Turns one EX-stage load/store request into a single NONSEQ AHB-Lite transfer,
// holding the pipeline until the data phase completes.
//
// Ports:
//   clk_i, rst_ni                    clock, asynchronous active-low reset
//   req_valid_i/we/size/unsigned     load/store request, held while stall_o=1
//   req_addr_i, req_wdata_i          byte address, right-aligned store data
//   kill_i                           drops a request that has not been accepted yet
//   stall_o                          pipeline hold
//   rdata_o, rdata_valid_o           extended load data / completion pulse
//   misaligned_o, bus_err_o          error pulses
//   dmem_h*                          AHB-Lite master signals

module airi5c_dmem_ctrl #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            req_valid_i,
   input  logic            req_we_i,
   input  logic [1:0]      req_size_i,
   input  logic            req_unsigned_i,
   input  logic [XLEN-1:0] req_addr_i,
   input  logic [XLEN-1:0] req_wdata_i,
   input  logic            kill_i,
   output logic            stall_o,
   output logic [XLEN-1:0] rdata_o,
   output logic            rdata_valid_o,
   output logic            misaligned_o,
   output logic            bus_err_o,
   output logic [XLEN-1:0] dmem_haddr_o,
   output logic            dmem_hwrite_o,
   output logic [2:0]      dmem_hsize_o,
   output logic [1:0]      dmem_htrans_o,
   output logic [XLEN-1:0] dmem_hwdata_o,
   input  logic [XLEN-1:0] dmem_hrdata_i,
   input  logic            dmem_hready_i,
   input  logic            dmem_hresp_i
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADDR = 2'd1;
   localparam logic [1:0] S_DATA = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] addr_q;
   logic [XLEN-1:0] wdata_q;
   logic [1:0]      size_q;
   logic            we_q;
   logic            unsigned_q;

   logic [1:0]      size_n;
   logic            mis;
   logic            accept;
   logic            done;
   logic [XLEN-1:0] wdata_lanes;
   logic [XLEN-1:0] byte_shift;
   logic [7:0]      ld_byte;
   logic [15:0]     ld_half;
   logic [XLEN-1:0] ld_ext;

   // size 11 behaves exactly like a word access, so fold it early.
   assign size_n = req_size_i[1] ? 2'b10 : req_size_i;

   assign mis    = ((size_n == 2'b01) & req_addr_i[0]) |
                   ((size_n == 2'b10) & (|req_addr_i[1:0]));
   assign accept = (state_q == S_IDLE) & req_valid_i & ~kill_i & ~mis;
   assign done   = (state_q == S_DATA) & dmem_hready_i;

   always_comb begin
      case (size_n)
         2'b00:   wdata_lanes = {(XLEN/8){req_wdata_i[7:0]}};
         2'b01:   wdata_lanes = {(XLEN/16){req_wdata_i[15:0]}};
         default: wdata_lanes = req_wdata_i;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept)        state_d = S_ADDR;
         S_ADDR:  if (dmem_hready_i) state_d = S_DATA;
         S_DATA:  if (dmem_hready_i) state_d = S_IDLE;
         default:                    state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         size_q     <= 2'b00;
         we_q       <= 1'b0;
         unsigned_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            addr_q     <= req_addr_i;
            wdata_q    <= wdata_lanes;
            size_q     <= size_n;
            we_q       <= req_we_i;
            unsigned_q <= req_unsigned_i;
         end
      end
   end

   // Lane select uses the registered address offset of the accepted request.
   assign byte_shift = dmem_hrdata_i >> {addr_q[1:0], 3'b000};
   assign ld_byte    = byte_shift[7:0];
   assign ld_half    = addr_q[1] ? dmem_hrdata_i[31:16] : dmem_hrdata_i[15:0];

   always_comb begin
      case (size_q)
         2'b00:   ld_ext = {{(XLEN-8){ld_byte[7] & ~unsigned_q}}, ld_byte};
         2'b01:   ld_ext = {{(XLEN-16){ld_half[15] & ~unsigned_q}}, ld_half};
         default: ld_ext = dmem_hrdata_i;
      endcase
   end

   assign stall_o       = accept | (state_q == S_ADDR) |
                          ((state_q == S_DATA) & ~dmem_hready_i);
   assign misaligned_o  = (state_q == S_IDLE) & req_valid_i & ~kill_i & mis;
   assign rdata_valid_o = done & ~dmem_hresp_i;
   assign bus_err_o     = done & dmem_hresp_i;
   assign rdata_o       = (rdata_valid_o & ~we_q) ? ld_ext : '0;

   assign dmem_htrans_o = (state_q == S_ADDR) ? 2'b10 : 2'b00;
   assign dmem_haddr_o  = (state_q == S_ADDR) ? addr_q : '0;
   assign dmem_hwrite_o = (state_q == S_ADDR) & we_q;
   assign dmem_hsize_o  = (state_q == S_ADDR) ? {1'b0, size_q} : 3'b000;
   assign dmem_hwdata_o = (state_q == S_DATA) ? wdata_q : '0;

endmodule

// File: tb/tb_airi5c_dmem_ctrl.sv
// tb/tb_airi5c_dmem_ctrl.sv - scoreboard bench for airi5c_dmem_ctrl
module tb_airi5c_dmem_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_we_i = 1'b0;
   logic [1:0]  req_size_i = 2'b00;
   logic        req_unsigned_i = 1'b0;
   logic [31:0] req_addr_i = '0;
   logic [31:0] req_wdata_i = '0;
   logic        kill_i = 1'b0;
   logic        stall_o;
   logic [31:0] rdata_o;
   logic        rdata_valid_o;
   logic        misaligned_o;
   logic        bus_err_o;
   logic [31:0] dmem_haddr_o;
   logic        dmem_hwrite_o;
   logic [2:0]  dmem_hsize_o;
   logic [1:0]  dmem_htrans_o;
   logic [31:0] dmem_hwdata_o;
   logic [31:0] dmem_hrdata_i = '0;
   logic        dmem_hready_i = 1'b1;
   logic        dmem_hresp_i = 1'b0;

   airi5c_dmem_ctrl #(.XLEN(32)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_size_i(req_size_i),
      .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .kill_i(kill_i), .stall_o(stall_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
      .misaligned_o(misaligned_o), .bus_err_o(bus_err_o),
      .dmem_haddr_o(dmem_haddr_o), .dmem_hwrite_o(dmem_hwrite_o), .dmem_hsize_o(dmem_hsize_o),
      .dmem_htrans_o(dmem_htrans_o), .dmem_hwdata_o(dmem_hwdata_o),
      .dmem_hrdata_i(dmem_hrdata_i), .dmem_hready_i(dmem_hready_i), .dmem_hresp_i(dmem_hresp_i)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] haddr;
      logic        hwrite;
      logic [2:0]  hsize;
      int          cyc;
   } addr_t;

   // kind: 0 = completion, 1 = bus error, 2 = misaligned
   typedef struct {
      int          kind;
      logic [31:0] rdata;
      logic [31:0] hwdata;
      logic        we;
      int          cyc;
   } resp_t;

   addr_t addr_q[$];
   resp_t resp_q[$];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: samples on the falling edge, pops expectations on every DUT event.
   logic in_addr_prev = 1'b0;
   always @(negedge clk_i) begin
      addr_t a;
      resp_t r;
      int kind;
      if (rst_ni) begin
         if (dmem_htrans_o == 2'b10) begin
            chk("stall_in_addr_phase", {31'b0, stall_o}, 32'd1);
            if (!in_addr_prev) begin
               if (addr_q.size() == 0) begin
                  chk("unexpected_addr_phase", 32'd1, 32'd0);
               end else begin
                  a = addr_q.pop_front();
                  chk("haddr", dmem_haddr_o, a.haddr);
                  chk("hwrite", {31'b0, dmem_hwrite_o}, {31'b0, a.hwrite});
                  chk("hsize", {29'b0, dmem_hsize_o}, {29'b0, a.hsize});
                  chk("addr_phase_cycle", cyc, a.cyc);
               end
            end
         end
         if (rdata_valid_o | bus_err_o | misaligned_o) begin
            kind = misaligned_o ? 2 : (bus_err_o ? 1 : 0);
            chk("single_event", {29'b0, misaligned_o, bus_err_o, rdata_valid_o} & ({29'b0, misaligned_o, bus_err_o, rdata_valid_o} - 32'd1), 32'd0);
            if (resp_q.size() == 0) begin
               chk("unexpected_event", 32'd1, 32'd0);
            end else begin
               r = resp_q.pop_front();
               chk("event_kind", kind, r.kind);
               chk("event_cycle", cyc, r.cyc);
               chk("stall_at_event", {31'b0, stall_o}, 32'd0);
               if (kind == 0) chk("rdata", rdata_o, r.rdata);
               if (kind == 0 && r.we) chk("hwdata", dmem_hwdata_o, r.hwdata);
               if (kind == 2) chk("htrans_on_misaligned", {30'b0, dmem_htrans_o}, 32'd0);
            end
         end
      end
      in_addr_prev = rst_ni && (dmem_htrans_o == 2'b10);
   end

   task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata);
      req_valid_i = 1'b1;
      req_we_i = we;
      req_size_i = size;
      req_unsigned_i = uns;
      req_addr_i = addr;
      req_wdata_i = wdata;
   endtask

   // Full transfer; called 1 time unit after a rising edge.
   task automatic xfer(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] hrdata, input int waits, input logic hresp,
                       input logic [31:0] exp_rdata, input logic [31:0] exp_hwdata);
      int c0;
      resp_t r;
      addr_t a;
      c0 = cyc;
      drive_req(we, size, uns, addr, wdata);
      a.haddr = addr; a.hwrite = we; a.hsize = {1'b0, size}; a.cyc = c0 + 1;
      addr_q.push_back(a);
      r.kind = hresp ? 1 : 0; r.rdata = exp_rdata; r.hwdata = exp_hwdata;
      r.we = we; r.cyc = c0 + 2 + waits;
      resp_q.push_back(r);
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      dmem_hrdata_i = hrdata;
      dmem_hresp_i = hresp;
      dmem_hready_i = (waits == 0);
      for (int i = 0; i < waits; i++) begin
         @(posedge clk_i); #1;
         dmem_hready_i = (i == waits - 1);
      end
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      dmem_hrdata_i = '0;
      dmem_hresp_i = 1'b0;
      dmem_hready_i = 1'b1;
   endtask

   task automatic misaligned(input logic [1:0] size, input logic [31:0] addr);
      resp_t r;
      r.kind = 2; r.rdata = '0; r.hwdata = '0; r.we = 1'b0; r.cyc = cyc;
      resp_q.push_back(r);
      drive_req(1'b0, size, 1'b0, addr, '0);
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk_i);
      #1;
      chk("reset_outputs",
          {14'b0, stall_o, rdata_valid_o, misaligned_o, bus_err_o, dmem_hwrite_o,
           dmem_hsize_o, dmem_htrans_o, 8'b0},
          32'd0);
      chk("reset_rdata_haddr_hwdata", rdata_o | dmem_haddr_o | dmem_hwdata_o, 32'd0);
      rst_ni = 1'b1;
      @(posedge clk_i); #1;

      // LW, zero wait states
      xfer(1'b0, 2'b10, 1'b0, 32'h100, '0, 32'hDEADBEEF, 0, 1'b0, 32'hDEADBEEF, '0);
      // LB / LBU on the top byte lane, back to back
      xfer(1'b0, 2'b00, 1'b0, 32'h103, '0, 32'h80123456, 0, 1'b0, 32'hFFFFFF80, '0);
      xfer(1'b0, 2'b00, 1'b1, 32'h103, '0, 32'h80123456, 0, 1'b0, 32'h00000080, '0);
      // LB lane 1, positive
      xfer(1'b0, 2'b00, 1'b0, 32'h101, '0, 32'h00007F00, 0, 1'b0, 32'h0000007F, '0);
      // LH upper half signed, LHU lower half
      xfer(1'b0, 2'b01, 1'b0, 32'h102, '0, 32'h80017FFF, 0, 1'b0, 32'hFFFF8001, '0);
      xfer(1'b0, 2'b01, 1'b1, 32'h100, '0, 32'h1234F00D, 1, 1'b0, 32'h0000F00D, '0);
      // SH with two wait states
      xfer(1'b1, 2'b01, 1'b0, 32'h202, 32'h1234ABCD, '0, 2, 1'b0, 32'h0, 32'hABCDABCD);
      // SB, SW
      xfer(1'b1, 2'b00, 1'b0, 32'h301, 32'h000000A5, '0, 0, 1'b0, 32'h0, 32'hA5A5A5A5);
      xfer(1'b1, 2'b10, 1'b0, 32'h400, 32'hCAFEF00D, '0, 0, 1'b0, 32'h0, 32'hCAFEF00D);

      // misaligned word and half
      misaligned(2'b10, 32'h101);
      misaligned(2'b01, 32'h103);
      @(posedge clk_i); #1;

      // bus error in the data phase, then a normal load right after
      xfer(1'b0, 2'b10, 1'b0, 32'h104, '0, 32'h11111111, 0, 1'b1, '0, '0);
      xfer(1'b0, 2'b10, 1'b0, 32'h108, '0, 32'h22222222, 0, 1'b0, 32'h22222222, '0);

      // killed request: nothing may happen
      drive_req(1'b0, 2'b10, 1'b0, 32'h600, '0);
      kill_i = 1'b1;
      #1 chk("stall_when_killed", {31'b0, stall_o}, 32'd0);
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      kill_i = 1'b0;
      @(posedge clk_i); #1;
      chk("htrans_after_kill", {30'b0, dmem_htrans_o}, 32'd0);

      // reset during an address-phase wait: abort without a completion pulse
      begin
         addr_t a;
         a.haddr = 32'h500; a.hwrite = 1'b0; a.hsize = 3'b010; a.cyc = cyc + 1;
         addr_q.push_back(a);
         drive_req(1'b0, 2'b10, 1'b0, 32'h500, '0);
         dmem_hready_i = 1'b0;
         @(posedge clk_i); #1;
         @(posedge clk_i); #1;
         chk("htrans_in_addr_wait", {30'b0, dmem_htrans_o}, 32'h2);
         rst_ni = 1'b0;
         req_valid_i = 1'b0;
         #1;
         chk("htrans_on_reset", {30'b0, dmem_htrans_o}, 32'd0);
         chk("stall_on_reset", {31'b0, stall_o}, 32'd0);
         @(posedge clk_i); #1;
         rst_ni = 1'b1;
         dmem_hready_i = 1'b1;
         repeat (3) @(posedge clk_i);
         #1;
         chk("htrans_after_reset", {30'b0, dmem_htrans_o}, 32'd0);
      end

      // a load after the abort must still work
      xfer(1'b0, 2'b10, 1'b0, 32'h10C, '0, 32'h0BADF00D, 0, 1'b0, 32'h0BADF00D, '0);

      repeat (4) @(posedge clk_i);
      chk("addr_queue_drained", addr_q.size(), 32'd0);
      chk("resp_queue_drained", resp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
